// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: ISA opcodes, flag bit positions and the
// per-opcode flag update rule.
package alu_pkg;

  localparam logic [3:0] ADD    = 4'h0;
  localparam logic [3:0] SUB    = 4'h1;
  localparam logic [3:0] RED    = 4'h2;
  localparam logic [3:0] XOR    = 4'h3;
  localparam logic [3:0] SLL    = 4'h4;
  localparam logic [3:0] SRA    = 4'h5;
  localparam logic [3:0] ROR    = 4'h6;
  localparam logic [3:0] PADDSB = 4'h7;
  localparam logic [3:0] LW     = 4'h8;
  localparam logic [3:0] SW     = 4'h9;
  localparam logic [3:0] LHB    = 4'hA;
  localparam logic [3:0] LLB    = 4'hB;
  localparam logic [3:0] HLT    = 4'hF;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Bits set in the mask are overwritten when a result of this opcode loads.
  function automatic logic [2:0] flag_update_mask(input logic [3:0] op);
    logic [2:0] mask;
    mask = '0;
    case (op)
      ADD, SUB: begin
        mask[FLAG_N] = 1'b1;
        mask[FLAG_V] = 1'b1;
        mask[FLAG_Z] = 1'b1;
      end
      XOR, SLL, SRA, ROR: mask[FLAG_Z] = 1'b1;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/alu_lane_adder.sv
// Saturating signed adder for one PADDSB lane; clamps to the lane's signed range.
module alu_lane_adder #(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a_i,
  input  logic [LANE-1:0] b_i,
  output logic [LANE-1:0] sum_o
);

  localparam logic [LANE-1:0] LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0] LANE_MIN = {1'b1, {(LANE-1){1'b0}}};

  logic [LANE:0] ext_sum;
  logic          ovf;

  assign ext_sum = {a_i[LANE-1], a_i} + {b_i[LANE-1], b_i};
  // The two top bits of the sign-extended sum disagree exactly on overflow.
  assign ovf     = ext_sum[LANE] ^ ext_sum[LANE-1];
  assign sum_o   = ovf ? (ext_sum[LANE] ? LANE_MIN : LANE_MAX) : ext_sum[LANE-1:0];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and an internal N/V/Z flag
// register. Define ALU_PIPE_SAT_EN to make ADD/SUB saturate instead of wrap.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_flags
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int NBYTES = WIDTH / 8;
  localparam int NLANES = WIDTH / LANE;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [2:0]       out_flags_q, out_flags_d;

  logic             stage2_free;
  logic             accept;

  logic [WIDTH:0]   add_ext, sub_ext;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] add_res, sub_res;
  logic [WIDTH-1:0] red_res, sll_res, sra_res, ror_res, pad_res, mem_res;
  logic [WIDTH-1:0] lhb_res, llb_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [2:0]       upd_mask, new_flags;

  // Handshake
  assign stage2_free = !out_valid_q || out_ready;
  assign in_ready    = !rst && (!s1_valid_q || stage2_free);
  assign accept      = in_valid && in_ready;

  // ADD / SUB on sign-extended operands so the overflow test is local
  assign add_ext = {s1_a_q[WIDTH-1], s1_a_q} + {s1_b_q[WIDTH-1], s1_b_q};
  assign sub_ext = {s1_a_q[WIDTH-1], s1_a_q} - {s1_b_q[WIDTH-1], s1_b_q};
  assign add_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
  assign sub_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  assign add_res = add_ovf ? (add_ext[WIDTH] ? SAT_MIN : SAT_MAX) : add_ext[WIDTH-1:0];
  assign sub_res = sub_ovf ? (sub_ext[WIDTH] ? SAT_MIN : SAT_MAX) : sub_ext[WIDTH-1:0];
`else
  assign add_res = add_ext[WIDTH-1:0];
  assign sub_res = sub_ext[WIDTH-1:0];
`endif

  // NOTE: every always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    red_res = '0;
    for (int i = 0; i < NBYTES; i++) begin
      red_res = red_res
              + {{(WIDTH-8){s1_a_q[8*i+7]}}, s1_a_q[8*i +: 8]}
              + {{(WIDTH-8){s1_b_q[8*i+7]}}, s1_b_q[8*i +: 8]};
    end
  end

  assign shamt   = s1_b_q[SHW-1:0];
  assign sll_res = s1_a_q << shamt;
  assign sra_res = $signed(s1_a_q) >>> shamt;
  assign ror_res = WIDTH'({s1_a_q, s1_a_q} >> shamt);
  assign mem_res = {s1_a_q[WIDTH-1:1], 1'b0} + {s1_b_q[WIDTH-2:0], 1'b0};

  always_comb begin
    lhb_res        = s1_a_q;
    lhb_res[15:8]  = s1_b_q[7:0];
    llb_res        = s1_a_q;
    llb_res[7:0]   = s1_b_q[7:0];
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    alu_lane_adder #(
      .LANE (LANE)
    ) u_lane (
      .a_i   (s1_a_q[g*LANE +: LANE]),
      .b_i   (s1_b_q[g*LANE +: LANE]),
      .sum_o (pad_res[g*LANE +: LANE])
    );
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (s1_op_q)
      ADD:     begin alu_res = add_res; alu_ovf = add_ovf; end
      SUB:     begin alu_res = sub_res; alu_ovf = sub_ovf; end
      RED:     alu_res = red_res;
      XOR:     alu_res = s1_a_q ^ s1_b_q;
      SLL:     alu_res = sll_res;
      SRA:     alu_res = sra_res;
      ROR:     alu_res = ror_res;
      PADDSB:  alu_res = pad_res;
      LW, SW:  alu_res = mem_res;
      LHB:     alu_res = lhb_res;
      LLB:     alu_res = llb_res;
      HLT:     alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign upd_mask          = flag_update_mask(s1_op_q);
  assign new_flags[FLAG_N] = alu_res[WIDTH-1];
  assign new_flags[FLAG_V] = alu_ovf;
  assign new_flags[FLAG_Z] = (alu_res == '0);

  // Stage 2 refills whenever it is free; stage 1 is overwritten on accept.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (stage2_free) begin
      out_valid_d = s1_valid_q;
      s1_valid_d  = 1'b0;
      if (s1_valid_q) begin
        out_result_d = alu_res;
        out_flags_d  = (new_flags & upd_mask) | (out_flags_q & ~upd_mask);
      end
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = opcode;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  // NOTE: operand registers carry no reset; they are only observed while
  // s1_valid_q is set, which reset clears.
  always_ff @(posedge clk) begin
    s1_op_q <= s1_op_d;
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, randomized traffic with
// backpressure against an arithmetic reference model, and reset scenarios.
module tb_alu_pipe;

  localparam int W = 16;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [2:0]   out_flags;

  int total  = 0;
  int bad    = 0;
  int cycles = 0;

  logic [2:0]   mflags;
  logic [W+2:0] exp_q[$];
  logic [W+2:0] obs_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   fl;
  } vec_t;

  alu_pipe #(
    .WIDTH (W),
    .LANE  (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference model: returns {flags, result} from signed integer arithmetic.
  function automatic logic [W+2:0] model_op(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [2:0] fl);
    longint sa, sb, s, lo, hi, x;
    logic [W-1:0] r;
    logic [2:0] f;
    logic v;
    int sh;
    lo = -(longint'(1) <<< (W-1));
    hi = (longint'(1) <<< (W-1)) - 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % W);
    r  = '0;
    f  = fl;
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sa + sb : sa - sb;
        v = (s > hi) || (s < lo);
`ifdef ALU_PIPE_SAT_EN
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
`endif
        r = W'(s);
        f = {r[W-1], v, r == '0};
      end
      4'h2: begin
        s = 0;
        for (int i = 0; i < W/8; i++)
          s += longint'($signed(a[i*8 +: 8])) + longint'($signed(b[i*8 +: 8]));
        r = W'(s);
      end
      4'h3: r = a ^ b;
      4'h4: r = W'(longint'(a) << sh);
      4'h5: r = W'(sa >>> sh);
      4'h6: for (int i = 0; i < W; i++) r[i] = a[(i + sh) % W];
      4'h7: begin
        for (int j = 0; j < W/L; j++) begin
          x = longint'($signed(a[j*L +: L])) + longint'($signed(b[j*L +: L]));
          if (x > (2**(L-1)) - 1) x = (2**(L-1)) - 1;
          if (x < -(2**(L-1))) x = -(2**(L-1));
          r[j*L +: L] = L'(x);
        end
      end
      4'h8, 4'h9: r = W'((longint'(a) / 2) * 2 + longint'(b) * 2);
      4'hA: begin r = a; r[15:8] = b[7:0]; end
      4'hB: begin r = a; r[7:0] = b[7:0]; end
      default: r = '0;
    endcase
    if (op inside {4'h3, 4'h4, 4'h5, 4'h6}) f[0] = (r == '0);
    return {f, r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: records handshakes into the model/observation queues.
  // Called and returns at 1 time unit after a rising edge.
  task automatic tick(output bit acc);
    logic [W+2:0] e;
    #1;
    acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      obs_q.delete();
      mflags = '0;
    end else begin
      if (out_valid && out_ready) obs_q.push_back({out_flags, out_result});
      if (in_valid && in_ready) begin
        acc = 1'b1;
        e = model_op(opcode, in_a, in_b, mflags);
        mflags = e[W+2:W];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    in_valid = 1'b1;
    opcode   = op;
    in_a     = a;
    in_b     = b;
    acc      = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) tick(acc);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: op %h not accepted within 50 cycles", op);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && obs_q.size() < n; c++) tick(acc);
    if (obs_q.size() < n) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d results, need %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1;
    tick(acc);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result: got %h need 0000", out_result); end
    total++; if (out_flags !== 3'b000) begin bad++; $display("FAIL reset_out_flags: got %b need 000", out_flags); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b need 0 while rst", in_ready); end
    rst = 1'b0;
    tick(acc);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready: got %b need 1", in_ready); end
  endtask

  // Presented in the cycle opened by edge k: hidden after k+1, visible after k+2.
  task automatic test_latency();
    bit acc;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1; opcode = 4'h0; in_a = 16'h0001; in_b = 16'h0002;
    tick(acc);
    in_valid = 1'b0;
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL latency_accept: got %b need 1", acc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: out_valid %b need 0", out_valid); end
    tick(acc);
    total++; if (out_valid !== 1'b1 || out_result !== 16'h0003 || out_flags !== 3'b000) begin
      bad++; $display("FAIL latency_result: valid=%b res=%h fl=%b need 1/0003/000", out_valid, out_result, out_flags);
    end
    tick(acc);
  endtask

  task automatic test_directed();
    vec_t v[17];
    int start;
`ifdef ALU_PIPE_SAT_EN
    v[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010};
    v[13] = '{4'h0, 16'h8000, 16'hFFFF, 16'h8000, 3'b110};
    v[14] = '{4'h9, 16'h0001, 16'h7FFF, 16'hFFFE, 3'b110};
    v[15] = '{4'h1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 3'b010};
`else
    v[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 3'b110};
    v[13] = '{4'h0, 16'h8000, 16'hFFFF, 16'h7FFF, 3'b010};
    v[14] = '{4'h9, 16'h0001, 16'h7FFF, 16'hFFFE, 3'b010};
    v[15] = '{4'h1, 16'h7FFF, 16'hFFFF, 16'h8000, 3'b110};
`endif
    v[1]  = '{4'h1, 16'h1234, 16'h1234, 16'h0000, 3'b001};
    v[2]  = '{4'h3, 16'hFFFF, 16'h0000, 16'hFFFF, 3'b000};
    v[3]  = '{4'h7, 16'h7F18, 16'h1118, 16'h7028, 3'b000};
    v[4]  = '{4'h2, 16'h0102, 16'h03FF, 16'h0005, 3'b000};
    v[5]  = '{4'h8, 16'h1235, 16'h0004, 16'h123C, 3'b000};
    v[6]  = '{4'h5, 16'h8000, 16'h0004, 16'hF800, 3'b000};
    v[7]  = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 3'b000};
    v[8]  = '{4'h4, 16'h0001, 16'h000F, 16'h8000, 3'b000};
    v[9]  = '{4'h4, 16'h8000, 16'h0001, 16'h0000, 3'b001};
    v[10] = '{4'hA, 16'h1234, 16'h00AB, 16'hAB34, 3'b001};
    v[11] = '{4'hB, 16'h1234, 16'h00CD, 16'h12CD, 3'b001};
    v[12] = '{4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b001};
    v[16] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 3'b001};
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1;
    start = cycles;
    foreach (v[i]) send(v[i].op, v[i].a, v[i].b);
    total++; if (cycles - start !== 17) begin
      bad++; $display("FAIL directed_throughput: %0d cycles for 17 ops, need 17", cycles - start);
    end
    drain(17);
    foreach (v[i]) begin
      if (i < obs_q.size()) begin
        total++;
        if (obs_q[i] !== {v[i].fl, v[i].res}) begin
          bad++;
          $display("FAIL directed_%0d op=%h: got res=%h fl=%b need res=%h fl=%b",
                   i, v[i].op, obs_q[i][W-1:0], obs_q[i][W+2:W], v[i].res, v[i].fl);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b0;
    send(4'h0, W'($urandom), W'($urandom));
    send(4'h3, W'($urandom), W'($urandom));
    in_valid = 1'b1; opcode = 4'h2; in_a = W'($urandom); in_b = W'($urandom);
    for (int c = 0; c < 3; c++) begin
      tick(acc);
      total++; if (acc !== 1'b0) begin bad++; $display("FAIL bp_third_accepted: cycle %0d acc=%b need 0", c, acc); end
      total++; if (out_valid !== 1'b1 || {out_flags, out_result} !== exp_q[0]) begin
        bad++; $display("FAIL bp_hold: valid=%b got %h need %h", out_valid, {out_flags, out_result}, exp_q[0]);
      end
    end
    out_ready = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_release_accept: acc=%b need 1", acc); end
    tick(acc);
    tick(acc);
    total++; if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
      bad++; $display("FAIL bp_count: got %0d results for %0d ops in 3 cycles, need 3", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_order_%0d: got %h need %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    exp_q.delete(); obs_q.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      opcode    = 4'($urandom_range(15));
      in_a      = pick();
      in_b      = pick();
      out_ready = ($urandom_range(9) < 7);
      tick(acc);
      if (out_valid) begin
        total++;
        if (obs_q.size() >= exp_q.size()) begin
          bad++; $display("FAIL random_spurious: out_valid with nothing pending, res=%h", out_result);
        end else if ({out_flags, out_result} !== exp_q[obs_q.size()]) begin
          bad++; $display("FAIL random_present cycle %0d: got %h need %h", c, {out_flags, out_result}, exp_q[obs_q.size()]);
        end
      end
    end
    drain(exp_q.size());
    total++; if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL random_count: got %0d results need %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_result_%0d: got %h need %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    bit acc;
    int stale;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b0;
    send(4'h1, 16'h0055, 16'h0055);
    send(4'h0, 16'h7FFF, 16'h0001);
    total++; if (out_valid !== 1'b1 || out_flags !== 3'b001) begin
      bad++; $display("FAIL midrst_setup: valid=%b fl=%b need 1/001", out_valid, out_flags);
    end
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; opcode = 4'h3; in_a = 16'hAAAA; in_b = 16'h5555;
    tick(acc);
    total++; if (out_valid !== 1'b0 || out_flags !== 3'b000 || in_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_clear: valid=%b fl=%b in_ready=%b need 0/000/0", out_valid, out_flags, in_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick(acc);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b need 1", in_ready); end
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale++;
      tick(acc);
    end
    total++; if (stale !== 0 || obs_q.size() !== 0) begin
      bad++; $display("FAIL midrst_stale: %0d stale valid cycles, %0d results, need 0", stale, obs_q.size());
    end
    send(4'h3, 16'h00F0, 16'h00F0);
    drain(1);
    total++; if (obs_q.size() !== 1 || obs_q[0] !== {3'b001, 16'h0000}) begin
      bad++; $display("FAIL midrst_after: got %0d results first=%h need 1 result 10000",
                      obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; in_a = '0; in_b = '0; mflags = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
